// File: rtl/types.sv
// Shared frame-buffer type definitions used by the command engines and the RAM port.
// Latency: none (types only).
// Backpressure: not applicable.
package types;
    typedef logic [11:0] fb_addr_t;
endpackage

// File: rtl/control_fb_write_arbiter_if.sv
// Bundle of the per-engine frame-buffer write ports and the shared RAM write port.
// Latency: none (wiring only); the arbiter registers every output it drives here.
// Backpressure: none; engines learn ownership only through gnt.
interface control_fb_write_arbiter_if #(
    parameter int NUM_REQ = 2
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                 req;
    logic [NUM_REQ-1:0]                 req_done;
    types::fb_addr_t [NUM_REQ-1:0]      req_addr;
    logic [NUM_REQ-1:0][7:0]            req_data;
    logic [NUM_REQ-1:0]                 req_we;

    logic [NUM_REQ-1:0]                 gnt;
    types::fb_addr_t                    ram_addr;
    logic [7:0]                         ram_data;
    logic                               ram_write_enable;
    logic                               ram_access_start;
    logic                               busy;
    logic [ID_W-1:0]                    active_id;

    // Arbiter side: takes the engine ports, drives grant and RAM port.
    modport slave (
        input  req, req_done, req_addr, req_data, req_we,
        output gnt, ram_addr, ram_data, ram_write_enable, ram_access_start, busy, active_id
    );

    // Engine/RAM side: drives the engine ports, observes grant and RAM port.
    modport master (
        output req, req_done, req_addr, req_data, req_we,
        input  gnt, ram_addr, ram_data, ram_write_enable, ram_access_start, busy, active_id
    );
endinterface

// File: rtl/control_fb_write_arbiter.sv
// Round-robin arbiter sharing one frame-buffer RAM write port among NUM_REQ engines; grant held per burst.
// Latency: grant 1 cycle after req seen in IDLE; granted writes reach the RAM 1 cycle after req_we.
// Backpressure: none; writes from non-granted engines are dropped (counted when FB_ARB_STATS_EN is defined).
module control_fb_write_arbiter #(
    parameter int NUM_REQ          = 2,
    parameter int HOLD_IDLE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    control_fb_write_arbiter_if.slave  bus
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]                drop_count
`endif
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(HOLD_IDLE_CYCLES + 1);
    localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_IDLE_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [ID_W-1:0]      ptr_q;
    logic [ID_W-1:0]      winner;
    logic [ID_W-1:0]      cand;
    logic                 win_vld;
    logic [CNT_W-1:0]     idle_cnt_q;
    logic                 fwd;
    logic                 release_now;

    logic [NUM_REQ-1:0]   gnt_q;
    logic [ID_W-1:0]      active_id_q;
    logic                 busy_q;
    types::fb_addr_t      ram_addr_q;
    logic [7:0]           ram_data_q;
    logic                 ram_we_q;
    logic                 ram_start_q;

    // Round-robin pick: first requesting index at or after the pointer, wrapping.
    always_comb begin
        winner  = ptr_q;
        cand    = ptr_q;
        win_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!win_vld && bus.req[cand]) begin
                winner  = cand;
                win_vld = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the forward/release decisions for the granted engine.
    always_comb begin
        state_d     = state_q;
        fwd         = 1'b0;
        release_now = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                fwd         = bus.req_we[active_id_q];
                release_now = bus.req_done[active_id_q] ||
                              (!bus.req[active_id_q] && (idle_cnt_q == HOLD_LAST));
                if (release_now) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered grant bookkeeping and the single write stage towards the RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            idle_cnt_q  <= '0;
            gnt_q       <= '0;
            active_id_q <= '0;
            busy_q      <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_start_q <= 1'b0;
        end else begin
            // A write that coincides with release is still forwarded.
            ram_we_q <= fwd;
            if (fwd) begin
                ram_addr_q  <= bus.req_addr[active_id_q];
                ram_data_q  <= bus.req_data[active_id_q];
                ram_start_q <= ~ram_start_q;
            end
            unique case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        gnt_q       <= ONE_HOT0 << winner;
                        active_id_q <= winner;
                        busy_q      <= 1'b1;
                        idle_cnt_q  <= '0;
                    end
                end
                GRANT: begin
                    // Saturate at the release threshold; release fires on the next low cycle anyway.
                    if (bus.req[active_id_q]) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q != HOLD_LAST) begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                    if (release_now) begin
                        gnt_q <= '0;
                    end
                end
                DRAIN: begin
                    ptr_q  <= (active_id_q == LAST_ID) ? '0 : active_id_q + 1'b1;
                    busy_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.gnt              = gnt_q;
    assign bus.active_id        = active_id_q;
    assign bus.busy             = busy_q;
    assign bus.ram_addr         = ram_addr_q;
    assign bus.ram_data         = ram_data_q;
    assign bus.ram_write_enable = ram_we_q;
    assign bus.ram_access_start = ram_start_q;

`ifdef FB_ARB_STATS_EN
    logic [15:0] drop_q;

    // Count cycles where any engine without the grant tries to write; saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else if ((|(bus.req_we & ~gnt_q)) && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_control_fb_write_arbiter.sv
// Bench for the frame-buffer write arbiter: directed scenarios plus randomized traffic.
// Latency: model predicts the registered outputs after every clock edge.
// Backpressure: engines write freely; the model decides which writes must reach the RAM.
module tb_control_fb_write_arbiter;
    localparam int NUM_REQ = 2;
    localparam int HOLD    = 4;
    localparam int ID_W    = $clog2(NUM_REQ);

    logic clk   = 1'b0;
    logic reset = 1'b1;

    control_fb_write_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef FB_ARB_STATS_EN
    logic [15:0] drop_count;
`endif

    control_fb_write_arbiter #(
        .NUM_REQ          (NUM_REQ),
        .HOLD_IDLE_CYCLES (HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FB_ARB_STATS_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner = engine currently holding the grant (-1 none); drain = one dead cycle after release.
    logic [NUM_REQ-1:0] m_gnt   = '0;
    logic               m_busy  = 1'b0;
    logic [ID_W-1:0]    m_id    = '0;
    logic               m_we    = 1'b0;
    types::fb_addr_t    m_addr  = '0;
    logic [7:0]         m_data  = '0;
    logic               m_start = 1'b0;
    logic [15:0]        m_drop  = '0;
    int                 m_owner = -1;
    int                 m_ptr   = 0;
    int                 m_low   = 0;
    bit                 m_drain = 1'b0;
    bit                 m_valid = 1'b0;

    always @(posedge clk) begin
        logic [ID_W-1:0] oi;
        bit found;
        int w;
        if (reset) begin
            m_gnt = '0; m_busy = 1'b0; m_id = '0; m_we = 1'b0;
            m_addr = '0; m_data = '0; m_start = 1'b0; m_drop = '0;
            m_owner = -1; m_ptr = 0; m_low = 0; m_drain = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (((bus.req_we & ~m_gnt) != '0) && (m_drop != 16'hFFFF))
                m_drop = m_drop + 16'd1;
            if (m_owner >= 0) begin
                oi   = ID_W'(m_owner);
                m_we = bus.req_we[oi];
                if (m_we) begin
                    m_addr  = bus.req_addr[oi];
                    m_data  = bus.req_data[oi];
                    m_start = ~m_start;
                end
                m_low = bus.req[oi] ? 0 : m_low + 1;
                if (bus.req_done[oi] || (m_low >= HOLD)) begin
                    m_gnt   = '0;
                    m_ptr   = (m_owner + 1) % NUM_REQ;
                    m_owner = -1;
                    m_drain = 1'b1;
                end
            end else if (m_drain) begin
                m_drain = 1'b0;
                m_busy  = 1'b0;
                m_we    = 1'b0;
            end else begin
                m_we  = 1'b0;
                found = 1'b0;
                w     = 0;
                for (int k = 0; k < NUM_REQ; k++) begin
                    oi = ID_W'((m_ptr + k) % NUM_REQ);
                    if (!found && bus.req[oi]) begin
                        found = 1'b1;
                        w     = (m_ptr + k) % NUM_REQ;
                    end
                end
                if (found) begin
                    m_owner = w;
                    oi      = ID_W'(w);
                    m_gnt   = NUM_REQ'(1) << oi;
                    m_id    = oi;
                    m_busy  = 1'b1;
                    m_low   = 0;
                end
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("gnt",              32'(bus.gnt),              32'(m_gnt));
            chk("busy",             32'(bus.busy),             32'(m_busy));
            chk("active_id",        32'(bus.active_id),        32'(m_id));
            chk("ram_write_enable", 32'(bus.ram_write_enable), 32'(m_we));
            chk("ram_addr",         32'(bus.ram_addr),         32'(m_addr));
            chk("ram_data",         32'(bus.ram_data),         32'(m_data));
            chk("ram_access_start", 32'(bus.ram_access_start), 32'(m_start));
`ifdef FB_ARB_STATS_EN
            chk("drop_count",       32'(drop_count),           32'(m_drop));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.req      = '0;
        bus.req_done = '0;
        bus.req_we   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_addr[i] = '0;
            bus.req_data[i] = '0;
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        chk("rst_gnt",   32'(bus.gnt),              32'h0);
        chk("rst_busy",  32'(bus.busy),             32'h0);
        chk("rst_id",    32'(bus.active_id),        32'h0);
        chk("rst_we",    32'(bus.ram_write_enable), 32'h0);
        chk("rst_start", 32'(bus.ram_access_start), 32'h0);
        reset = 1'b0;

        // Single requester burst of 6 writes.
        bus.req = 2'b01;
        step();
        chk("burst_gnt",  32'(bus.gnt),              32'h1);
        chk("burst_busy", 32'(bus.busy),             32'h1);
        chk("burst_we0",  32'(bus.ram_write_enable), 32'h0);
        for (int k = 0; k < 6; k++) begin
            bus.req_we      = 2'b01;
            bus.req_addr[0] = types::fb_addr_t'(12'h100 + k);
            bus.req_data[0] = 8'(8'h10 + k);
            step();
            chk("burst_we",   32'(bus.ram_write_enable), 32'h1);
            chk("burst_data", 32'(bus.ram_data),         32'(8'h10 + k));
            chk("burst_addr", 32'(bus.ram_addr),         32'(12'h100 + k));
        end
        chk("burst_start_end", 32'(bus.ram_access_start), 32'h0);
        bus.req_we   = 2'b00;
        bus.req_done = 2'b01;
        step();
        chk("burst_drain_gnt",  32'(bus.gnt),  32'h0);
        chk("burst_drain_busy", 32'(bus.busy), 32'h1);
        bus.req_done = 2'b00;
        bus.req      = 2'b00;
        step();
        chk("burst_idle_busy", 32'(bus.busy), 32'h0);

        // Simultaneous request from reset pointer, then round-robin handover.
        reset = 1'b1;
        step();
        reset   = 1'b0;
        bus.req = 2'b11;
        step();
        chk("sim_gnt0", 32'(bus.gnt), 32'h1);
        bus.req_we      = 2'b10;
        bus.req_data[1] = 8'h77;
        bus.req_done    = 2'b01;
        step();
        chk("sim_drain_gnt", 32'(bus.gnt),              32'h0);
        chk("sim_no_e1_wr",  32'(bus.ram_write_enable), 32'h0);
        bus.req_done = 2'b00;
        bus.req_we   = 2'b00;
        step();
        chk("sim_idle_gnt", 32'(bus.gnt), 32'h0);
        step();
        chk("sim_gnt1", 32'(bus.gnt),       32'h2);
        chk("sim_id1",  32'(bus.active_id), 32'h1);
        bus.req_we      = 2'b10;
        bus.req_data[1] = 8'h5C;
        step();
        chk("sim_e1_we",   32'(bus.ram_write_enable), 32'h1);
        chk("sim_e1_data", 32'(bus.ram_data),         32'h5C);
        bus.req_we   = 2'b00;
        bus.req_done = 2'b10;
        step();
        bus.req_done = 2'b00;
        step();
        step();
        chk("rr_wrap_gnt0", 32'(bus.gnt), 32'h1);

        // Idle timeout: 3 low cycles keep the grant, 4 release it.
        bus.req = 2'b00;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold3_gnt", 32'(bus.gnt), 32'h1);
        end
        bus.req = 2'b01;
        step();
        chk("hold_back_gnt", 32'(bus.gnt), 32'h1);
        bus.req = 2'b00;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold4_gnt", 32'(bus.gnt), 32'h1);
        end
        step();
        chk("timeout_gnt",  32'(bus.gnt),  32'h0);
        chk("timeout_busy", 32'(bus.busy), 32'h1);
        step();
        chk("timeout_busy_low", 32'(bus.busy), 32'h0);

        // Done coincident with a write.
        bus.req = 2'b01;
        step();
        chk("dcw_gnt", 32'(bus.gnt), 32'h1);
        bus.req_we      = 2'b01;
        bus.req_done    = 2'b01;
        bus.req_data[0] = 8'hA5;
        step();
        chk("dcw_we",   32'(bus.ram_write_enable), 32'h1);
        chk("dcw_data", 32'(bus.ram_data),         32'hA5);
        chk("dcw_gnt0", 32'(bus.gnt),              32'h0);
        bus.req_we   = 2'b00;
        bus.req_done = 2'b00;
        bus.req      = 2'b00;
        step();
        chk("dcw_after_we", 32'(bus.ram_write_enable), 32'h0);

        // Reset during the third write of a burst.
        bus.req = 2'b01;
        step();
        for (int k = 0; k < 2; k++) begin
            bus.req_we      = 2'b01;
            bus.req_data[0] = 8'(8'h30 + k);
            step();
        end
        bus.req_we      = 2'b01;
        bus.req_data[0] = 8'h32;
        reset           = 1'b1;
        step();
        chk("mid_rst_gnt",   32'(bus.gnt),              32'h0);
        chk("mid_rst_we",    32'(bus.ram_write_enable), 32'h0);
        chk("mid_rst_data",  32'(bus.ram_data),         32'h0);
        chk("mid_rst_addr",  32'(bus.ram_addr),         32'h0);
        chk("mid_rst_start", 32'(bus.ram_access_start), 32'h0);
        chk("mid_rst_busy",  32'(bus.busy),             32'h0);
        reset      = 1'b0;
        bus.req_we = 2'b00;
        bus.req    = 2'b11;
        step();
        chk("post_rst_gnt", 32'(bus.gnt),              32'h1);
        chk("post_rst_we",  32'(bus.ram_write_enable), 32'h0);

`ifdef FB_ARB_STATS_EN
        bus.req_we = 2'b10;
        for (int k = 0; k < 5; k++) step();
        chk("drop_count5", 32'(drop_count), 32'h5);
        chk("drop_no_we",  32'(bus.ram_write_enable), 32'h0);
        bus.req_we = 2'b00;
`endif
        bus.req_done = 2'b01;
        step();
        clear_inputs();
        step();

        // Randomized traffic with sticky requests and occasional resets.
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 7) == 0) bus.req[i] = ~bus.req[i];
                bus.req_we[i]   = ($urandom_range(0, 1) == 1);
                bus.req_done[i] = ($urandom_range(0, 15) == 0);
                bus.req_addr[i] = types::fb_addr_t'($urandom);
                bus.req_data[i] = 8'($urandom);
            end
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;
        clear_inputs();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
